// File: rtl/phase_sequencer_pkg.sv
// Shared types and constants for the phase sequencer.
package phase_sequencer_pkg;

    localparam int NUM_PHASES_DEF = 5;
    localparam int PHASE_W        = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_HALTED
    } state_e;

endpackage

// File: rtl/phase_sequencer_button_conditioner.sv
// Raw button -> 2-flop synchronizer -> debounce -> one-cycle press pulse.
// The debounced level only flips after the synchronized level has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles, in either direction, so a
// held button yields a single pulse and must be released to re-arm.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          pressed_q, pressed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;
    logic          lvl_low;

    // Synchronize, then count consecutive cycles of disagreement with the
    // debounced level; fire the pulse on the release->pressed flip only.
    always_comb begin
        sync1_d   = btn_n;
        sync2_d   = sync1_q;
        pressed_d = pressed_q;
        cnt_d     = '0;
        pulse_d   = 1'b0;
        lvl_low   = ~sync2_q;
        if (lvl_low != pressed_q) begin
            if (cnt_q == CNT_MAX) begin
                pressed_d = lvl_low;
                pulse_d   = lvl_low;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Reset loads the released state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            pressed_q <= 1'b0;
            cnt_q     <= '0;
            pulse_q   <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            pressed_q <= pressed_d;
            cnt_q     <= cnt_d;
            pulse_q   <= pulse_d;
        end
    end

    assign press = pulse_q;

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: run/stop and single-step buttons, halt input,
// registered phase outputs and a completed-instruction counter.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int NUM_PHASES      = NUM_PHASES_DEF,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               exec_n,
    input  logic               step_n,
    input  logic               halt,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_valid,
    output logic               phase_last,
    output logic               running,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_count
);

    localparam logic [PHASE_W-1:0] LAST_PH = PHASE_W'(NUM_PHASES - 1);

    logic exec_press, step_press;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exec_btn (
        .clock (clock),
        .reset (reset),
        .btn_n (exec_n),
        .press (exec_press)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
        .clock (clock),
        .reset (reset),
        .btn_n (step_n),
        .press (step_press)
    );

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               phase_valid_q, phase_valid_d;
    logic               phase_last_q, phase_last_d;
    logic               stop_pending_q, stop_pending_d;
    logic               halt_pending_q, halt_pending_d;
    logic [CNT_W-1:0]   instr_count_q, instr_count_d;
    logic               halt_seen;

    // Next state, phase stepping and pending flags. A halt in the last phase
    // still counts for that boundary, hence halt_seen rather than the flop.
    always_comb begin
        halt_seen      = halt_pending_q | (halt & phase_valid_q);
        state_d        = state_q;
        phase_d        = phase_q;
        phase_valid_d  = phase_valid_q;
        stop_pending_d = stop_pending_q;
        halt_pending_d = halt_seen;
        instr_count_d  = instr_count_q + CNT_W'(phase_last_q);

        if (phase_valid_q)
            phase_d = phase_last_q ? '0 : phase_q + PHASE_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (exec_press || step_press) begin
                    state_d       = exec_press ? ST_RUN : ST_STEP;
                    phase_d       = '0;
                    phase_valid_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (exec_press)
                    stop_pending_d = 1'b1;
                if (phase_last_q) begin
                    if (halt_seen) begin
                        state_d       = ST_HALTED;
                        phase_valid_d = 1'b0;
                    end else if (stop_pending_d) begin
                        state_d       = ST_IDLE;
                        phase_valid_d = 1'b0;
                    end
                    stop_pending_d = 1'b0;
                    halt_pending_d = 1'b0;
                end
            end
            ST_STEP: begin
                if (phase_last_q) begin
                    state_d        = halt_seen ? ST_HALTED : ST_IDLE;
                    phase_valid_d  = 1'b0;
                    stop_pending_d = 1'b0;
                    halt_pending_d = 1'b0;
                end
            end
            ST_HALTED: begin
                phase_d        = '0;
                phase_valid_d  = 1'b0;
                stop_pending_d = 1'b0;
                halt_pending_d = 1'b0;
            end
            default: begin
                state_d       = ST_IDLE;
                phase_d       = '0;
                phase_valid_d = 1'b0;
            end
        endcase

        phase_last_d = phase_valid_d && (phase_d == LAST_PH);
    end

    // State and output registers; reset abandons any in-flight instruction.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            phase_q        <= '0;
            phase_valid_q  <= 1'b0;
            phase_last_q   <= 1'b0;
            stop_pending_q <= 1'b0;
            halt_pending_q <= 1'b0;
            instr_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            phase_valid_q  <= phase_valid_d;
            phase_last_q   <= phase_last_d;
            stop_pending_q <= stop_pending_d;
            halt_pending_q <= halt_pending_d;
            instr_count_q  <= instr_count_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;
    assign phase_last  = phase_last_q;
    assign running     = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign halted      = (state_q == ST_HALTED);
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer (NUM_PHASES=5, DEBOUNCE_CYCLES=4).
// Inputs change and outputs are sampled on the falling edge; k counts rising
// edges since the stimulus of each scenario was applied.
module tb_phase_sequencer;

    logic        clock;
    logic        reset, exec_n, step_n, halt;
    logic [2:0]  phase;
    logic        phase_valid, phase_last, running, halted;
    logic [15:0] instr_count;

    logic        reset2, exec2_n, step2_n, halt2;
    logic [2:0]  phase2;
    logic        phase_valid2, phase_last2, running2, halted2;
    logic [3:0]  instr_count2;

    int n_checks = 0;
    int n_fail   = 0;

    phase_sequencer u_dut (
        .clock(clock), .reset(reset), .exec_n(exec_n), .step_n(step_n),
        .halt(halt), .phase(phase), .phase_valid(phase_valid),
        .phase_last(phase_last), .running(running), .halted(halted),
        .instr_count(instr_count)
    );

    phase_sequencer #(.CNT_W(4)) u_dut4 (
        .clock(clock), .reset(reset2), .exec_n(exec2_n), .step_n(step2_n),
        .halt(halt2), .phase(phase2), .phase_valid(phase_valid2),
        .phase_last(phase_last2), .running(running2), .halted(halted2),
        .instr_count(instr_count2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Checks all observable outputs of the main DUT against hand-derived values.
    task automatic test_reset();
        reset = 1'b0; exec_n = 1'b1; step_n = 1'b1; halt = 1'b0;
        tick(); tick();
        n_checks++; if (phase !== 3'd0) begin n_fail++; $display("FAIL reset_phase got %0d exp 0", phase); end
        n_checks++; if (phase_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", phase_valid); end
        n_checks++; if (phase_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b exp 0", phase_last); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %b exp 0", running); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b exp 0", halted); end
        n_checks++; if (instr_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", instr_count); end
        reset = 1'b1;
        tick();
    endtask

    // exec held 10 cycles: press pulse at k=6, RUN with phase 0 at k=7.
    task automatic test_run_entry();
        int ep, ec; logic ev;
        exec_n = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            ev = (k >= 7);
            ep = ev ? (k - 7) % 5 : 0;
            ec = int'(k >= 12) + int'(k >= 17);
            n_checks++; if (phase_valid !== ev) begin n_fail++; $display("FAIL run_valid k=%0d got %b exp %b", k, phase_valid, ev); end
            n_checks++; if (phase !== 3'(ep)) begin n_fail++; $display("FAIL run_phase k=%0d got %0d exp %0d", k, phase, ep); end
            n_checks++; if (phase_last !== (ev && ep == 4)) begin n_fail++; $display("FAIL run_last k=%0d got %b", k, phase_last); end
            n_checks++; if (running !== ev) begin n_fail++; $display("FAIL run_running k=%0d got %b exp %b", k, running, ev); end
            n_checks++; if (instr_count !== 16'(ec)) begin n_fail++; $display("FAIL run_count k=%0d got %0d exp %0d", k, instr_count, ec); end
            if (k == 10) exec_n = 1'b1;
        end
    endtask

    // Entered at phase 1 with count 2; stop pulse lands in phase 2.
    task automatic test_stop();
        int ep, ec; logic ev;
        exec_n = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            ev = (k <= 8);
            ep = ev ? (1 + k) % 5 : 0;
            ec = 2 + int'(k >= 4) + int'(k >= 9);
            n_checks++; if (phase_valid !== ev) begin n_fail++; $display("FAIL stop_valid k=%0d got %b exp %b", k, phase_valid, ev); end
            n_checks++; if (phase !== 3'(ep)) begin n_fail++; $display("FAIL stop_phase k=%0d got %0d exp %0d", k, phase, ep); end
            n_checks++; if (running !== ev) begin n_fail++; $display("FAIL stop_running k=%0d got %b exp %b", k, running, ev); end
            n_checks++; if (instr_count !== 16'(ec)) begin n_fail++; $display("FAIL stop_count k=%0d got %0d exp %0d", k, instr_count, ec); end
            if (k == 10) exec_n = 1'b1;
        end
    endtask

    // Three consecutive instructions, stop requested by a second press in the third.
    task automatic test_back_to_back();
        int ep, ec; logic ev;
        exec_n = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            ev = (k >= 7) && (k <= 21);
            ep = ev ? (k - 7) % 5 : 0;
            ec = 4 + int'(k >= 12) + int'(k >= 17) + int'(k >= 22);
            n_checks++; if (phase_valid !== ev) begin n_fail++; $display("FAIL b2b_valid k=%0d got %b exp %b", k, phase_valid, ev); end
            n_checks++; if (phase !== 3'(ep)) begin n_fail++; $display("FAIL b2b_phase k=%0d got %0d exp %0d", k, phase, ep); end
            n_checks++; if (instr_count !== 16'(ec)) begin n_fail++; $display("FAIL b2b_count k=%0d got %0d exp %0d", k, instr_count, ec); end
            if (k == 6)  exec_n = 1'b1;
            if (k == 12) exec_n = 1'b0;
            if (k == 22) exec_n = 1'b1;
        end
    endtask

    // Step held exactly 4 synchronized cycles; exec press mid-step is ignored.
    task automatic test_step();
        int ep, ec; logic ev;
        step_n = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            tick();
            ev = (k >= 7) && (k <= 11);
            ep = ev ? k - 7 : 0;
            ec = 7 + int'(k >= 12);
            n_checks++; if (phase_valid !== ev) begin n_fail++; $display("FAIL step_valid k=%0d got %b exp %b", k, phase_valid, ev); end
            n_checks++; if (phase !== 3'(ep)) begin n_fail++; $display("FAIL step_phase k=%0d got %0d exp %0d", k, phase, ep); end
            n_checks++; if (running !== ev) begin n_fail++; $display("FAIL step_running k=%0d got %b exp %b", k, running, ev); end
            n_checks++; if (instr_count !== 16'(ec)) begin n_fail++; $display("FAIL step_count k=%0d got %0d exp %0d", k, instr_count, ec); end
            if (k == 4)  begin step_n = 1'b1; exec_n = 1'b0; end
            if (k == 14) exec_n = 1'b1;
        end
    endtask

    // halt during phase 1 of a run; HALTED ignores presses; reset recovers.
    task automatic test_halt();
        int ep, ec; logic ev;
        exec_n = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            ev = (k >= 7) && (k <= 11);
            ep = ev ? k - 7 : 0;
            ec = 8 + int'(k >= 12);
            n_checks++; if (phase_valid !== ev) begin n_fail++; $display("FAIL halt_valid k=%0d got %b exp %b", k, phase_valid, ev); end
            n_checks++; if (phase !== 3'(ep)) begin n_fail++; $display("FAIL halt_phase k=%0d got %0d exp %0d", k, phase, ep); end
            n_checks++; if (halted !== (k >= 12)) begin n_fail++; $display("FAIL halt_halted k=%0d got %b", k, halted); end
            n_checks++; if (instr_count !== 16'(ec)) begin n_fail++; $display("FAIL halt_count k=%0d got %0d exp %0d", k, instr_count, ec); end
            if (k == 8)  halt = 1'b1;
            if (k == 9)  halt = 1'b0;
            if (k == 10) exec_n = 1'b1;
        end
        exec_n = 1'b0; step_n = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_checks++; if (halted !== 1'b1 || phase_valid !== 1'b0 || running !== 1'b0 || phase !== 3'd0)
                begin n_fail++; $display("FAIL halted_hold k=%0d halted=%b valid=%b running=%b phase=%0d exp 1/0/0/0", k, halted, phase_valid, running, phase); end
            if (k == 10) begin exec_n = 1'b1; step_n = 1'b1; end
        end
        reset = 1'b0;
        tick();
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset_halted got %b exp 0", halted); end
        n_checks++; if (instr_count !== 16'd0) begin n_fail++; $display("FAIL halt_reset_count got %0d exp 0", instr_count); end
        n_checks++; if (running !== 1'b0 || phase_valid !== 1'b0) begin n_fail++; $display("FAIL halt_reset_idle running=%b valid=%b exp 0/0", running, phase_valid); end
        reset = 1'b1;
        tick();
    endtask

    // 3-cycle glitch and idle halt are ignored; simultaneous presses pick RUN.
    task automatic test_glitch();
        int ep, ec; logic ev;
        exec_n = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_checks++; if (phase_valid !== 1'b0 || running !== 1'b0) begin n_fail++; $display("FAIL glitch_idle k=%0d valid=%b running=%b exp 0/0", k, phase_valid, running); end
            if (k == 1) halt = 1'b1;
            if (k == 3) begin exec_n = 1'b1; halt = 1'b0; end
        end
        exec_n = 1'b0; step_n = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            ev = (k >= 7);
            ep = ev ? (k - 7) % 5 : 0;
            ec = int'(k >= 12) + int'(k >= 17);
            n_checks++; if (phase_valid !== ev) begin n_fail++; $display("FAIL both_valid k=%0d got %b exp %b", k, phase_valid, ev); end
            n_checks++; if (phase !== 3'(ep)) begin n_fail++; $display("FAIL both_phase k=%0d got %0d exp %0d", k, phase, ep); end
            n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL both_halted k=%0d got %b exp 0", k, halted); end
            n_checks++; if (instr_count !== 16'(ec)) begin n_fail++; $display("FAIL both_count k=%0d got %0d exp %0d", k, instr_count, ec); end
            if (k == 10) begin exec_n = 1'b1; step_n = 1'b1; end
        end
    endtask

    // 4-bit counter wraps after 16 instructions; reset at phase 3 drops it.
    task automatic test_wrap();
        reset2 = 1'b1;
        exec2_n = 1'b0;
        for (int k = 1; k <= 96; k++) begin
            tick();
            if (k == 10) exec2_n = 1'b1;
            if (k == 7) begin
                n_checks++; if (phase_valid2 !== 1'b1 || phase2 !== 3'd0) begin n_fail++; $display("FAIL wrap_start valid=%b phase=%0d exp 1/0", phase_valid2, phase2); end
            end
            if (k == 86) begin
                n_checks++; if (instr_count2 !== 4'd15) begin n_fail++; $display("FAIL wrap_15 got %0d exp 15", instr_count2); end
            end
            if (k == 87) begin
                n_checks++; if (instr_count2 !== 4'd0) begin n_fail++; $display("FAIL wrap_0 got %0d exp 0", instr_count2); end
            end
            if (k == 91) begin
                n_checks++; if (phase_last2 !== 1'b1) begin n_fail++; $display("FAIL wrap_last got %b exp 1", phase_last2); end
            end
            if (k == 92) begin
                n_checks++; if (instr_count2 !== 4'd1) begin n_fail++; $display("FAIL wrap_1 got %0d exp 1", instr_count2); end
                n_checks++; if (phase2 !== 3'd0 || phase_valid2 !== 1'b1) begin n_fail++; $display("FAIL wrap_cont phase=%0d valid=%b exp 0/1", phase2, phase_valid2); end
            end
            if (k == 95) begin
                n_checks++; if (phase2 !== 3'd3) begin n_fail++; $display("FAIL wrap_ph3 got %0d exp 3", phase2); end
                reset2 = 1'b0;
            end
            if (k == 96) begin
                n_checks++; if (instr_count2 !== 4'd0) begin n_fail++; $display("FAIL wrap_rst_count got %0d exp 0", instr_count2); end
                n_checks++; if (phase2 !== 3'd0 || phase_valid2 !== 1'b0) begin n_fail++; $display("FAIL wrap_rst_phase phase=%0d valid=%b exp 0/0", phase2, phase_valid2); end
                n_checks++; if (running2 !== 1'b0 || halted2 !== 1'b0) begin n_fail++; $display("FAIL wrap_rst_state running=%b halted=%b exp 0/0", running2, halted2); end
            end
        end
        reset2 = 1'b1;
        tick();
    endtask

    initial begin
        reset2 = 1'b0; exec2_n = 1'b1; step2_n = 1'b1; halt2 = 1'b0;
        test_reset();
        test_run_entry();
        test_stop();
        test_back_to_back();
        test_step();
        test_halt();
        test_glitch();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
